// File: rtl/prio_sel_pkg.sv
// Shared types and helpers for the registered priority selector.
package prio_sel_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic int unsigned ch_w(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Find-first-set over N request bits, searching upward from a base index with wrap.
module prio_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic [W-1:0] grant,
  output logic         any
);

  always_comb begin
    int unsigned idx;
    grant = '0;
    any   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (int'(base) + k) % N;
      if (!any && req[idx]) begin
        grant = W'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_sel_reg.sv
// N_CH-channel priority selector with a one-entry registered valid/ready output.
// Define PRIO_SEL_RR_EN for round-robin arbitration; default is fixed priority (ch0 highest).
module prio_sel_reg
  import prio_sel_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CH_W  = ch_w(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  output logic [N_CH-1:0]         in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_ready
);

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   grant;
  logic              any;
  logic              load;
  logic              xfer;
  logic [WIDTH-1:0]  ch_data [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_slice
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  prio_pick #(
    .N (N_CH),
    .W (CH_W)
  ) u_pick (
    .req   (in_valid),
    .base  (ptr),
    .grant (grant),
    .any   (any)
  );

  assign out_valid = (state == FULL);

  // Grant depends only on handshake signals, never on in_data.
  always_comb begin
    load      = (state == EMPTY) || out_ready;
    xfer      = load && any && !rst;
    in_ready  = '0;
    if (xfer) in_ready[grant] = 1'b1;
    state_nxt = state;
    if (xfer)
      state_nxt = FULL;
    else if (state == FULL && out_ready)
      state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_ch   <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        out_data <= ch_data[grant];
        out_ch   <= grant;
      end
    end
  end

`ifdef PRIO_SEL_RR_EN
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (xfer)
      ptr <= (grant == CH_W'(N_CH - 1)) ? '0 : grant + 1'b1;
  end
`else
  assign ptr = '0;
`endif

endmodule

// File: tb/tb_prio_sel_reg.sv
// Directed test of prio_sel_reg with N_CH=4, WIDTH=8.
module tb_prio_sel_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  prio_sel_reg #(
    .N_CH  (4),
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".ch"},    32'(out_ch),    32'(c));
  endtask

  logic [1:0] rr_exp [5];

  initial begin
`ifdef PRIO_SEL_RR_EN
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    rr_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif

    // Reset with all channels requesting
    rst = 1'b1; in_valid = 4'b1111; in_data = 32'h44332211; out_ready = 1'b0;
    tick(); tick();
    chk("rst.in_ready", 32'(in_ready), 32'h0);
    chk_out("rst", 1'b0, 8'h00, 2'd0);

    // Priority: ch1 beats ch3
    rst = 1'b0; in_valid = 4'b1010; in_data = 32'h33_00_11_00; out_ready = 1'b1;
    #1 chk("prio.rdy1", 32'(in_ready), 32'b0010);
    tick();
    chk_out("prio.w1", 1'b1, 8'h11, 2'd1);
    in_valid = 4'b1000;
    #1 chk("prio.rdy3", 32'(in_ready), 32'b1000);
    tick();
    chk_out("prio.w3", 1'b1, 8'h33, 2'd3);
    in_valid = 4'b0000;
    #1 chk("prio.idle_rdy", 32'(in_ready), 32'h0);
    tick();
    chk_out("drain", 1'b0, 8'h33, 2'd3);

    // Backpressure
    in_valid = 4'b0010; in_data = 32'h00_00_11_00;
    tick();
    chk_out("bp.load", 1'b1, 8'h11, 2'd1);
    in_valid = 4'b0001; in_data = 32'h00_00_00_44; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp.stall_rdy", 32'(in_ready), 32'h0);
      tick();
      chk_out("bp.hold", 1'b1, 8'h11, 2'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp.release_rdy", 32'(in_ready), 32'b0001);
    tick();
    chk_out("bp.reload", 1'b1, 8'h44, 2'd0);
    in_valid = 4'b0000;
    tick();
    chk("bp.drain", 32'(out_valid), 32'h0);

    // Streaming on ch2
    in_valid = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'(i) << 16;
      #1 chk("stream.rdy", 32'(in_ready), 32'b0100);
      tick();
      chk_out("stream", 1'b1, 8'(i), 2'd2);
    end
    in_valid = 4'b0000;
    tick();
    chk("stream.end", 32'(out_valid), 32'h0);

    // Reset mid-operation discards held word
    in_valid = 4'b0001; in_data = 32'h0000005A;
    tick();
    chk_out("mid.full", 1'b1, 8'h5A, 2'd0);
    out_ready = 1'b0; in_data = 32'h00000077; rst = 1'b1;
    #1 chk("mid.rst_rdy", 32'(in_ready), 32'h0);
    tick();
    chk_out("mid.cleared", 1'b0, 8'h00, 2'd0);
    rst = 1'b0; in_valid = 4'b0000; out_ready = 1'b1;
    tick();
    chk("mid.no_deliver", 32'(out_valid), 32'h0);

    // All channels requesting: arbitration order
    in_valid = 4'b1111; in_data = 32'hA3A2A1A0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("arb", 1'b1, 8'hA0 + 8'(rr_exp[i]), rr_exp[i]);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
